// File: rtl/branch_predict_unit_if.sv
// Fetch/Execute-side signal bundle for the branch unit.
// The master side is the pipeline (PCs, Execute flags); the slave side is the branch unit.
interface branch_predict_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) ();

  // Fetch-side lookup
  logic [XLEN-1:0]  PCF;
  logic             PredTakenF;

  // Execute-side resolution
  logic             ValidE;
  logic             BranchE;
  logic [2:0]       TypeBranchE;
  logic             ZeroE;
  logic             LessE;
  logic [XLEN-1:0]  PCE;
  logic             PredTakenE;
  logic             NeedBranchE;
  logic             MispredictE;
  logic             RecoverTakenE;
  logic             IllegalBranchE;

  // Statistics
  logic [CNT_W-1:0] BranchCount;
  logic [CNT_W-1:0] MissCount;

  modport master (
    output PCF, ValidE, BranchE, TypeBranchE, ZeroE, LessE, PCE, PredTakenE,
    input  PredTakenF, NeedBranchE, MispredictE, RecoverTakenE, IllegalBranchE,
    input  BranchCount, MissCount
  );

  modport slave (
    input  PCF, ValidE, BranchE, TypeBranchE, ZeroE, LessE, PCE, PredTakenE,
    output PredTakenF, NeedBranchE, MispredictE, RecoverTakenE, IllegalBranchE,
    output BranchCount, MissCount
  );

endinterface

// File: rtl/branch_predict_unit.sv
// RV32I branch unit: resolves conditional branches in Execute, owns a 2-bit-counter
// branch history table for Fetch predictions, flags mispredicts and keeps statistics.
module branch_predict_unit #(
  parameter int         XLEN     = 32,
  parameter int         IDX_W    = 6,
  parameter logic [1:0] CTR_INIT = 2'b01,
  parameter bit         PRED_EN  = 1'b1,
  parameter int         CNT_W    = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  branch_predict_unit_if.slave bus
);

  localparam int ENTRIES = 1 << IDX_W;

  // Saturating 2-bit counter step: up toward 11, down toward 00.
  function automatic logic [1:0] ctrNext(input logic [1:0] c, input logic up);
    if (up) begin
      return (c == 2'b11) ? c : c + 2'b01;
    end else begin
      return (c == 2'b00) ? c : c - 2'b01;
    end
  endfunction

  // Statistics counter step that holds at all-ones.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  logic [1:0]       bhtCtr_r [ENTRIES];
  logic [CNT_W-1:0] branchCount_r;
  logic [CNT_W-1:0] missCount_r;

  logic [IDX_W-1:0] fetchIdx_s;
  logic [IDX_W-1:0] execIdx_s;
  logic             cond_s;
  logic             illegal_s;
  logic             legalBranch_s;
  logic             needBranch_s;
  logic             mispredict_s;
  logic             aliasClean_s;
  logic             updEn_s;
  logic             updUp_s;

  // Word-aligned PCs: drop the two byte-offset bits, keep the low IDX_W word bits.
  assign fetchIdx_s = IDX_W'(bus.PCF[XLEN-1:2]);
  assign execIdx_s  = IDX_W'(bus.PCE[XLEN-1:2]);

  // Branch condition decode from funct3; 010/011 are not branches and never take.
  always_comb begin
    cond_s = 1'b0;
    case (bus.TypeBranchE)
      3'b000:         cond_s = bus.ZeroE;
      3'b001:         cond_s = ~bus.ZeroE;
      3'b100, 3'b110: cond_s = bus.LessE;
      3'b101, 3'b111: cond_s = ~bus.LessE;
      default:        cond_s = 1'b0;
    endcase
  end

  assign illegal_s     = bus.ValidE & bus.BranchE & (bus.TypeBranchE[2:1] == 2'b01);
  assign legalBranch_s = bus.ValidE & bus.BranchE & ~illegal_s;
  assign needBranch_s  = bus.ValidE & bus.BranchE & cond_s;
  // A non-branch that Fetch predicted taken means an aliased BHT entry.
  assign aliasClean_s  = bus.ValidE & ~bus.BranchE & bus.PredTakenE;
  assign mispredict_s  = bus.ValidE & ((bus.BranchE & (needBranch_s ^ bus.PredTakenE)) |
                                       (~bus.BranchE & bus.PredTakenE));

  // Select the BHT write for this cycle: train on legal branches, decay aliased entries.
  always_comb begin
    updEn_s = 1'b0;
    updUp_s = 1'b0;
    if (legalBranch_s) begin
      updEn_s = 1'b1;
      updUp_s = needBranch_s;
    end else if (aliasClean_s) begin
      updEn_s = 1'b1;
      updUp_s = 1'b0;
    end else begin
      updEn_s = 1'b0;
      updUp_s = 1'b0;
    end
  end

  // BHT storage: reset to CTR_INIT, otherwise one saturating update per cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bhtCtr_r[i] <= CTR_INIT;
      end
    end else if (updEn_s) begin
      bhtCtr_r[execIdx_s] <= ctrNext(bhtCtr_r[execIdx_s], updUp_s);
    end
  end

  // Statistics counters, both saturating and independently enabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      branchCount_r <= {CNT_W{1'b0}};
      missCount_r   <= {CNT_W{1'b0}};
    end else begin
      if (legalBranch_s) begin
        branchCount_r <= satInc(branchCount_r);
      end
      if (mispredict_s) begin
        missCount_r <= satInc(missCount_r);
      end
    end
  end

  // Lookup reads the stored value only, so a same-cycle write is seen one cycle later.
  assign bus.PredTakenF     = PRED_EN & bhtCtr_r[fetchIdx_s][1];
  assign bus.NeedBranchE    = needBranch_s;
  assign bus.MispredictE    = mispredict_s;
  assign bus.RecoverTakenE  = needBranch_s;
  assign bus.IllegalBranchE = illegal_s;
  assign bus.BranchCount    = branchCount_r;
  assign bus.MissCount      = missCount_r;

endmodule
